multiport_regfile: RTL

MULTIPORT_REGFILE -- requirements
Module: multiport_regfile

---
 rtl/regfile_pkg.sv | 16 +
 rtl/regfile_scoreboard.sv | 66 ++++++
 rtl/multiport_regfile.sv | 126 ++++++++++++
 3 files changed

// File: rtl/regfile_pkg.sv
// Shared constants and types for the multiport register file.
// Default widths, the hard-wired zero register address and the
// default register word type live here so every file agrees on them.
package regfile_pkg;

  localparam int DEF_WIDTH     = 32;
  localparam int DEF_ADD_WIDTH = 5;
  localparam int DEF_NU_REG    = 32;
  localparam int DEF_NUM_RD    = 3;

  // Register 0 always reads zero and never becomes busy.
  localparam int ZERO_REG      = 0;

  typedef logic [DEF_WIDTH-1:0] reg_word_t;

endpackage

// File: rtl/regfile_scoreboard.sv
// Busy-bit tracker for the register file.
// One busy bit per register: an issue marks its destination as pending,
// a writeback clears it, and an issue wins over a writeback to the same
// register in the same edge (the new producer is still outstanding).
// The population count of the busy bits is registered alongside them.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int ADD_WIDTH = DEF_ADD_WIDTH,
  parameter int NU_REG    = DEF_NU_REG
) (
  input  logic                 CLK,
  input  logic                 RESET,
  input  logic                 issue_en_i,
  input  logic [ADD_WIDTH-1:0] issue_addr_i,
  input  logic                 we0_i,
  input  logic [ADD_WIDTH-1:0] wa0_i,
  input  logic                 we1_i,
  input  logic [ADD_WIDTH-1:0] wa1_i,
  output logic [NU_REG-1:0]    busy_o,
  output logic [ADD_WIDTH:0]   busy_cnt_o
);

  logic [NU_REG-1:0]  busy_q;
  logic [NU_REG-1:0]  busy_d;
  logic [ADD_WIDTH:0] cnt_q;
  logic [ADD_WIDTH:0] cnt_d;

  // The zero register can never be pending.
  assign busy_d[ZERO_REG] = 1'b0;

  genvar gi;
  generate
    for (gi = ZERO_REG + 1; gi < NU_REG; gi++) begin : g_bit
      logic issue_hit;
      logic write_hit;
      assign issue_hit  = issue_en_i && (issue_addr_i == ADD_WIDTH'(gi));
      assign write_hit  = (we0_i && (wa0_i == ADD_WIDTH'(gi))) ||
                          (we1_i && (wa1_i == ADD_WIDTH'(gi)));
      assign busy_d[gi] = issue_hit | (busy_q[gi] & ~write_hit);
    end
  endgenerate

  // Count the next-state busy bits so the count lands with the bits.
  always_comb begin
    cnt_d = '0;
    for (int i = 0; i < NU_REG; i++) begin
      cnt_d = cnt_d + {{ADD_WIDTH{1'b0}}, busy_d[i]};
    end
  end

  // Busy bits and their count, cleared immediately by reset.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      busy_q <= '0;
      cnt_q  <= '0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
    end
  end

  assign busy_o     = busy_q;
  assign busy_cnt_o = cnt_q;

endmodule

// File: rtl/multiport_regfile.sv
// Multiport register file: two write ports (ALU and load writeback),
// NUM_RD combinational read ports, and a busy-bit scoreboard.
// Register 0 is hard-wired to zero; addresses at or above NU_REG read 0.
// Write port 1 has priority over write port 0 on an address collision.
// Optional feature: define MULTIPORT_REGFILE_BYPASS_EN to forward
// same-cycle write data to matching read ports (WD1 over WD0), which
// also reports those ports as not busy.
module multiport_regfile
  import regfile_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int ADD_WIDTH = DEF_ADD_WIDTH,
  parameter int NU_REG    = DEF_NU_REG,
  parameter int NUM_RD    = DEF_NUM_RD
) (
  input  logic                        CLK,
  input  logic                        RESET,
  input  logic                        WE0,
  input  logic [ADD_WIDTH-1:0]        WA0,
  input  logic [WIDTH-1:0]            WD0,
  input  logic                        WE1,
  input  logic [ADD_WIDTH-1:0]        WA1,
  input  logic [WIDTH-1:0]            WD1,
  input  logic [NUM_RD*ADD_WIDTH-1:0] RA,
  output logic [NUM_RD*WIDTH-1:0]     RD,
  output logic [NUM_RD-1:0]           RD_BUSY,
  input  logic                        ISSUE_EN,
  input  logic [ADD_WIDTH-1:0]        ISSUE_ADDR,
  output logic [ADD_WIDTH:0]          BUSY_CNT
);

  logic [WIDTH-1:0]  rf_words [NU_REG];
  logic [NU_REG-1:0] busy_vec;

  assign rf_words[ZERO_REG] = '0;

  genvar gi;
  generate
    for (gi = ZERO_REG + 1; gi < NU_REG; gi++) begin : g_reg
      logic [WIDTH-1:0] word_q;
      logic [WIDTH-1:0] word_d;

      // Next value: port 1 is applied last so it wins a collision.
      always_comb begin
        word_d = word_q;
        if (WE0 && (WA0 == ADD_WIDTH'(gi))) begin
          word_d = WD0;
        end
        if (WE1 && (WA1 == ADD_WIDTH'(gi))) begin
          word_d = WD1;
        end
      end

      // Storage word, cleared immediately by reset.
      always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
          word_q <= '0;
        end else begin
          word_q <= word_d;
        end
      end

      assign rf_words[gi] = word_q;
    end
  endgenerate

  regfile_scoreboard #(
    .ADD_WIDTH (ADD_WIDTH),
    .NU_REG    (NU_REG)
  ) u_scoreboard (
    .CLK          (CLK),
    .RESET        (RESET),
    .issue_en_i   (ISSUE_EN),
    .issue_addr_i (ISSUE_ADDR),
    .we0_i        (WE0),
    .wa0_i        (WA0),
    .we1_i        (WE1),
    .wa1_i        (WA1),
    .busy_o       (busy_vec),
    .busy_cnt_o   (BUSY_CNT)
  );

  genvar gk;
  generate
    for (gk = 0; gk < NUM_RD; gk++) begin : g_rd
      logic [ADD_WIDTH-1:0] addr;
      logic [WIDTH-1:0]     word;
      logic                 busy;

      assign addr = RA[gk*ADD_WIDTH +: ADD_WIDTH];

      // Address decode; unmatched (out-of-range) addresses fall through to 0.
      always_comb begin
        word = '0;
        busy = 1'b0;
        for (int r = 0; r < NU_REG; r++) begin
          if (addr == ADD_WIDTH'(r)) begin
            word = rf_words[r];
            busy = busy_vec[r];
`ifdef MULTIPORT_REGFILE_BYPASS_EN
            if (r != ZERO_REG) begin
              if (WE0 && (WA0 == ADD_WIDTH'(r))) begin
                word = WD0;
                busy = 1'b0;
              end
              if (WE1 && (WA1 == ADD_WIDTH'(r))) begin
                word = WD1;
                busy = 1'b0;
              end
            end
`endif
          end
        end
        // Outputs are forced quiet for the whole reset window.
        if (!RESET) begin
          word = '0;
          busy = 1'b0;
        end
      end

      assign RD[gk*WIDTH +: WIDTH] = word;
      assign RD_BUSY[gk]           = busy;
    end
  endgenerate

endmodule
